// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle MUL/DIV hold, memory wait freeze.
// Optional stall-cycle counter is built only when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        id_muldiv,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_wait,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  // Busy hold lasts MULDIV_CYCLES-1 cycles; the issuing cycle is the first EX cycle.
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       started_q, started_d;
  logic       load_use;

  assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == id_ex_rd)) ||
                     (id_rs2_used && (id_rs2 == id_ex_rd)));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the branches infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    started_d    = 1'b1;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_flush  = 1'b1;
    ex_mem_flush = 1'b1;

    if (started_q) begin
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            // Whole pipe frozen; writes already 0.
          end else if (ex_branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, push a bubble into EX while the load moves on.
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            id_ex_flush  = 1'b1;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if (id_muldiv) begin
              state_d = MD_BUSY;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        MD_BUSY: begin
          if (!mem_wait) begin
            ex_mem_write = 1'b1;
            ex_mem_flush = 1'b1;
            cnt_d        = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign md_busy = (state_q == MD_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= 4'd0;
      started_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (started_q && !pc_write && !mem_wait && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 32'd0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
